// File: rtl/cbus_ram_responder.sv
// cbus RAM responder: latency-delayed single/burst read/write slave
// backed by a 2^ADDR_BITS x 64-bit byte-writable memory.
module cbus_ram_responder #(
    parameter int ADDR_BITS = 10,
    parameter int LATENCY   = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        valid,
    input  logic [63:0] addr,
    input  logic [63:0] wdata,
    input  logic [1:0]  burst,
    input  logic [7:0]  len,
    input  logic [7:0]  wstrobe,
    output logic [63:0] rdata,
    output logic        ready,
    output logic        last
);

    localparam int DEPTH = 1 << ADDR_BITS;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        XFER = 2'd2
    } state_t;

    state_t                 state_q, state_d;
    logic [3:0]             lat_q, lat_d;
    logic [7:0]             beat_q, beat_d;
    logic [7:0]             len_q, len_d;
    logic [1:0]             burst_q, burst_d;
    logic                   wr_q, wr_d;
    logic [ADDR_BITS-1:0]   idx_q, idx_d, idx_next;
    logic                   ready_q, ready_d;
    logic                   last_q, last_d;
    logic [ADDR_BITS-1:0]   wrap_mask;
    logic                   wrap_ok;
    logic                   wr_en;
    logic [63:0]            mem [DEPTH];

    // Only the word-index bits of addr matter; the rest are deliberately dropped.
    logic unused_addr_bits;
    assign unused_addr_bits = ^{addr[63:ADDR_BITS+3], addr[2:0]};

    // Next word index after the current beat, by burst type.
    always_comb begin
        wrap_mask = ADDR_BITS'(len_q);
        wrap_ok   = (burst_q == 2'b10) &&
                    ((len_q == 8'd1) || (len_q == 8'd3) || (len_q == 8'd7) || (len_q == 8'd15));
        idx_next  = idx_q;
        if (burst_q == 2'b00) begin
            idx_next = idx_q;
        end else if (wrap_ok) begin
            idx_next = (idx_q & ~wrap_mask) | ((idx_q + ADDR_BITS'(1)) & wrap_mask);
        end else begin
            idx_next = idx_q + ADDR_BITS'(1);
        end
    end

    // Next-state and registered-output logic of the transaction FSM.
    always_comb begin
        state_d = state_q;
        lat_d   = lat_q;
        beat_d  = beat_q;
        len_d   = len_q;
        burst_d = burst_q;
        wr_d    = wr_q;
        idx_d   = idx_q;
        ready_d = 1'b0;
        last_d  = 1'b0;
        case (state_q)
            IDLE: begin
                if (valid) begin
                    idx_d   = addr[ADDR_BITS+2:3];
                    len_d   = len;
                    burst_d = burst;
                    wr_d    = |wstrobe;
                    lat_d   = 4'(LATENCY);
                    beat_d  = '0;
                    state_d = WAIT;
                end
            end
            WAIT: begin
                if (!valid) begin
                    lat_d   = '0;
                    state_d = IDLE;
                end else if (lat_q == 4'd1) begin
                    // Counter reaches zero this edge: first beat is presented next cycle.
                    lat_d   = '0;
                    beat_d  = '0;
                    ready_d = 1'b1;
                    last_d  = (len_q == 8'd0);
                    state_d = XFER;
                end else begin
                    lat_d = lat_q - 4'd1;
                end
            end
            XFER: begin
                if (!valid || last_q) begin
                    state_d = IDLE;
                end else begin
                    beat_d  = beat_q + 8'd1;
                    idx_d   = idx_next;
                    ready_d = 1'b1;
                    last_d  = ((beat_q + 8'd1) == len_q);
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // State and control registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            lat_q   <= '0;
            beat_q  <= '0;
            len_q   <= '0;
            burst_q <= '0;
            wr_q    <= 1'b0;
            idx_q   <= '0;
            ready_q <= 1'b0;
            last_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            lat_q   <= lat_d;
            beat_q  <= beat_d;
            len_q   <= len_d;
            burst_q <= burst_d;
            wr_q    <= wr_d;
            idx_q   <= idx_d;
            ready_q <= ready_d;
            last_q  <= last_d;
        end
    end

    // A beat writes only while the initiator still holds valid and reset is low.
    assign wr_en = (state_q == XFER) && wr_q && valid && !reset;

    // Byte-enabled memory write; contents survive reset.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            for (int unsigned i = 0; i < 8; i++) begin
                if (wstrobe[i]) begin
                    mem[idx_q][i*8 +: 8] <= wdata[i*8 +: 8];
                end
            end
        end
    end

    assign rdata = ready_q ? mem[idx_q] : '0;
    assign ready = ready_q;
    assign last  = last_q;

endmodule
